// File: rtl/mul_iter_ctrl_pkg.sv
// Shared definitions for the iterative multiplier sequencer: FSM states and MUL op encodings.
package mul_iter_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ABS_A  = 3'd1,
      ST_ABS_B  = 3'd2,
      ST_CALC   = 3'd3,
      ST_NEG_LO = 3'd4,
      ST_NEG_HI = 3'd5,
      ST_DONE   = 3'd6
   } state_t;

   typedef enum logic [1:0] {
      OP_MUL    = 2'd0,
      OP_MULH   = 2'd1,
      OP_MULHSU = 2'd2,
      OP_MULHU  = 2'd3
   } mul_op_t;

   // Decoder/EXU helper: returns {a_signed, b_signed} for a MUL op.
   function automatic logic [1:0] op_signs(input mul_op_t op);
      case (op)
         OP_MULH:   op_signs = 2'b11;
         OP_MULHSU: op_signs = 2'b10;
         default:   op_signs = 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/mul_iter_ctrl_cla.sv
// WIDTH-bit adder with carry in/out, shared by every step of the multiplier sequence.
module mul_iter_ctrl_cla #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_co
);

   logic [WIDTH-1:0] w_g;
   logic [WIDTH-1:0] w_p;

   assign w_g = i_a & i_b;
   assign w_p = i_a ^ i_b;

   always_comb begin : carry_chain
      logic v_c;
      v_c   = i_cin;
      o_sum = '0;
      for (int i = 0; i < WIDTH; i++) begin
         o_sum[i] = w_p[i] ^ v_c;
         v_c      = w_g[i] | (w_p[i] & v_c);
      end
      o_co = v_c;
   end

endmodule

// File: rtl/mul_iter_ctrl.sv
// Iterative shift-add multiplier sequencer; one adder is time-shared across magnitude,
// partial-product and result-negation steps to produce a 2*WIDTH-bit product.
module mul_iter_ctrl
   import mul_iter_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             a_signed,
   input  logic             b_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result_hi,
   output logic [WIDTH-1:0] result_lo
);

   localparam int CW = $clog2(WIDTH) + 1;

   state_t           r_state;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [CW-1:0]    r_cnt;
   logic             r_b_neg;
   logic             r_neg;
   logic             r_neg_c;
   logic             r_in_ready;
   logic             r_out_valid;

   logic [WIDTH-1:0] w_add_a;
   logic [WIDTH-1:0] w_add_b;
   logic             w_cin;
   logic [WIDTH-1:0] w_sum;
   logic             w_co;
   logic             w_a_neg;
   logic             w_b_neg;

   assign w_a_neg = a_signed & a[WIDTH-1];
   assign w_b_neg = b_signed & b[WIDTH-1];

   // Negations are ~x + 1 via cin; the high-half negation ripples the low-half carry in.
   always_comb begin
      w_add_a = '0;
      w_add_b = '0;
      w_cin   = 1'b0;
      case (r_state)
         ST_ABS_A:  begin w_add_a = ~r_mcand; w_cin = 1'b1; end
         ST_ABS_B:  begin w_add_a = ~r_lo;    w_cin = 1'b1; end
         ST_CALC:   begin w_add_a = r_hi; w_add_b = r_lo[0] ? r_mcand : '0; end
         ST_NEG_LO: begin w_add_a = ~r_lo;    w_cin = 1'b1; end
         ST_NEG_HI: begin w_add_a = ~r_hi;    w_cin = r_neg_c; end
         default:   ;
      endcase
   end

   mul_iter_ctrl_cla #(.WIDTH(WIDTH)) u_cla (
      .i_a   (w_add_a),
      .i_b   (w_add_b),
      .i_cin (w_cin),
      .o_sum (w_sum),
      .o_co  (w_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_mcand     <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_cnt       <= '0;
         r_b_neg     <= 1'b0;
         r_neg       <= 1'b0;
         r_neg_c     <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else if (flush) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: if (in_valid && r_in_ready) begin
               r_mcand    <= a;
               r_lo       <= b;
               r_hi       <= '0;
               r_cnt      <= CW'(WIDTH);
               r_b_neg    <= w_b_neg;
               r_neg      <= w_a_neg ^ w_b_neg;
               r_in_ready <= 1'b0;
               r_state    <= w_a_neg ? ST_ABS_A : (w_b_neg ? ST_ABS_B : ST_CALC);
            end
            ST_ABS_A: begin
               r_mcand <= w_sum;
               r_state <= r_b_neg ? ST_ABS_B : ST_CALC;
            end
            ST_ABS_B: begin
               r_lo    <= w_sum;
               r_state <= ST_CALC;
            end
            ST_CALC: begin
               // Shift the carry-extended partial sum right into {hi,lo}.
               r_hi  <= {w_co, w_sum[WIDTH-1:1]};
               r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  if (r_neg) begin
                     r_state <= ST_NEG_LO;
                  end else begin
                     r_state     <= ST_DONE;
                     r_out_valid <= 1'b1;
                  end
               end
            end
            ST_NEG_LO: begin
               r_lo    <= w_sum;
               r_neg_c <= w_co;
               r_state <= ST_NEG_HI;
            end
            ST_NEG_HI: begin
               r_hi        <= w_sum;
               r_state     <= ST_DONE;
               r_out_valid <= 1'b1;
            end
            ST_DONE: if (out_ready) begin
               r_state     <= ST_IDLE;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign result_hi = r_hi;
   assign result_lo = r_lo;

endmodule

// File: tb/tb_mul_iter_ctrl.sv
// Scoreboard bench for mul_iter_ctrl: arithmetic reference model, random backpressure,
// directed flush / reset / stall scenarios.
module tb_mul_iter_ctrl;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         a_signed = 1'b0;
   logic         b_signed = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         out_ready = 1'b0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] result_hi;
   logic [W-1:0] result_lo;

   typedef struct {
      logic [2*W-1:0] prod;
      int             lat;
      int             acc;
   } exp_t;

   exp_t           sbq[$];
   int             errors = 0;
   int             checks = 0;
   int             cyc = 0;
   bit             hold = 0;
   bit             bp_low = 0;
   logic [2*W-1:0] held;

   mul_iter_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_signed  (a_signed),
      .b_signed  (b_signed),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result_hi (result_hi),
      .result_lo (result_lo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial forever begin
      @(posedge clk);
      #1;
      out_ready = bp_low ? 1'b0 : ($urandom_range(3) != 0);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic xs, input logic ys);
      logic [2*W+1:0] ex, ey, p;
      ex = {{(W+2){xs & x[W-1]}}, x};
      ey = {{(W+2){ys & y[W-1]}}, y};
      p  = ex * ey;
      return p[2*W-1:0];
   endfunction

   function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic xs, input logic ys);
      int an, bn;
      an = (xs && x[W-1]) ? 1 : 0;
      bn = (ys && y[W-1]) ? 1 : 0;
      return W + an + bn + 2 * (an ^ bn);
   endfunction

   // Monitor: first visible cycle of out_valid pops an expectation; later cycles check hold.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid) begin
            if (!hold) begin
               if (sbq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output: got %h_%h expected no output", result_hi, result_lo);
               end else begin
                  e = sbq.pop_front();
                  chk("product", {result_hi, result_lo}, e.prod);
                  chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                  held = e.prod;
                  hold = 1;
               end
            end else begin
               chk("stable_result", {result_hi, result_lo}, held);
               chk("in_ready_busy", in_ready, 1'b0);
            end
            if (out_ready) hold = 0;
         end
      end
   end

   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic xs, input logic ys, input bit push);
      int   n;
      exp_t e;
      @(posedge clk);
      #1;
      a = x; b = y; a_signed = xs; b_signed = ys; in_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 300);
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready=0 after %0d cycles expected 1", n);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      if (push) begin
         e.prod = ref_prod(x, y, xs, ys);
         e.lat  = ref_lat(x, y, xs, ys);
         e.acc  = cyc;
         sbq.push_back(e);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sbq.size() != 0 || out_valid || hold) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
      end
      @(negedge clk);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(7))
         0:       return '0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h0000_0001;
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      int seen;
      logic [W-1:0] x, y;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", in_ready, 1'b1);
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_hi", result_hi, '0);
      chk("reset_lo", result_lo, '0);
      rst_n = 1'b1;

      issue(32'd3, 32'd5, 1'b0, 1'b0, 1);
      issue(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1, 1);
      issue(32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1, 1'b1, 1);
      issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1);
      issue(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1);
      issue(32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1);
      drain();

      // Long stall in DONE: the monitor checks result/in_ready on every held cycle.
      bp_low = 1;
      issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 1);
      seen = 0;
      while (!out_valid && seen < 100) begin @(negedge clk); seen++; end
      repeat (10) @(negedge clk);
      bp_low = 0;
      drain();

      // Flush mid-CALC after 16 iterations; nothing may be produced.
      issue(32'd11, 32'd13, 1'b0, 1'b0, 0);
      repeat (16) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_in_ready", in_ready, 1'b1);
      chk("flush_out_valid", out_valid, 1'b0);
      seen = 0;
      repeat (40) begin @(negedge clk); if (out_valid) seen++; end
      chk("flush_no_output", 64'(seen), 64'd0);

      // Flush beats a simultaneous in_valid.
      @(posedge clk);
      #1; a = 32'd9; b = 32'd9; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1; in_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("flush_beats_valid", in_ready, 1'b1);
      issue(32'd7, 32'd6, 1'b0, 1'b0, 1);
      drain();

      // Async reset while in NEG_LO (-3*5: ABS_A, 32 CALC, then NEG_LO).
      issue(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1, 0);
      repeat (33) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_in_ready", in_ready, 1'b1);
      chk("rst_mid_out_valid", out_valid, 1'b0);
      chk("rst_mid_hi", result_hi, '0);
      chk("rst_mid_lo", result_lo, '0);
      #1 rst_n = 1'b1;
      issue(32'd3, 32'd5, 1'b0, 1'b0, 1);
      drain();

      for (int i = 0; i < 300; i++) begin
         x = pick();
         y = pick();
         issue(x, y, 1'($urandom_range(1)), 1'($urandom_range(1)), 1);
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
